// File: rtl/tmr_scrub_ctrl_if.sv
// Signal bundle between the TMR scrub controller and the replica datapath:
// replica observations and count request in, supervisory controls and status out.
interface tmr_scrub_ctrl_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          enable_in;
    logic [W-1:0]  q_a;
    logic [W-1:0]  q_b;
    logic [W-1:0]  q_c;
    logic          cnt_enable;
    logic [W-1:0]  voted_out;
    logic [2:0]    load_en;
    logic [W-1:0]  load_val;
    logic [2:0]    lane_dis;
    logic [CW-1:0] fault_cnt_a;
    logic [CW-1:0] fault_cnt_b;
    logic [CW-1:0] fault_cnt_c;
    logic          err_flag;
    logic          fatal;
    logic          busy;

    modport master (
        output enable_in, q_a, q_b, q_c,
        input  cnt_enable, voted_out, load_en, load_val, lane_dis,
               fault_cnt_a, fault_cnt_b, fault_cnt_c, err_flag, fatal, busy
    );

    modport slave (
        input  enable_in, q_a, q_b, q_c,
        output cnt_enable, voted_out, load_en, load_val, lane_dis,
               fault_cnt_a, fault_cnt_b, fault_cnt_c, err_flag, fatal, busy
    );
endinterface

// File: rtl/tmr_scrub_ctrl.sv
// Supervisor for a triple-redundant counter: votes, confirms single-lane faults,
// resyncs the faulty replica, locks out chronic lanes and flags uncorrectable states.
module tmr_scrub_ctrl #(
    parameter int W           = 8,
    parameter int CONFIRM     = 2,
    parameter int MAX_RETRY   = 2,
    parameter int FAULT_LIMIT = 3,
    parameter int CW          = 4
) (
    input  logic            clk,
    input  logic            rst,
    tmr_scrub_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_MON, S_CONF, S_LOAD, S_CHECK, S_FATAL} state_t;

    localparam int              RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [3:0]      CONFIRM_C = 4'(CONFIRM);
    localparam logic [RW-1:0]   RETRY_C   = RW'(MAX_RETRY);
    localparam logic [CW-1:0]   LIMIT_C   = CW'(FAULT_LIMIT);
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    state_t        r_state,    w_state_nxt;
    logic [3:0]    r_pcnt,     w_pcnt_nxt;
    logic [1:0]    r_flt_lane, w_flt_lane_nxt;
    logic [RW-1:0] r_retry,    w_retry_nxt;
    logic [W-1:0]  r_load_val, w_load_val_nxt;
    logic [2:0]    r_lane_dis, w_lane_dis_nxt;
    logic [CW-1:0] r_fault_cnt     [3];
    logic [CW-1:0] w_fault_cnt_nxt [3];

    logic          w_eq_ab, w_eq_bc, w_eq_ac;
    logic [W-1:0]  w_voted;
    logic          w_clean, w_single, w_fatal_cond;
    logic [1:0]    w_single_lane;
    logic [2:0]    w_flt_oh;
    logic [CW-1:0] w_cnt_cur, w_cnt_inc;

    assign w_eq_ab = (bus.q_a == bus.q_b);
    assign w_eq_bc = (bus.q_b == bus.q_c);
    assign w_eq_ac = (bus.q_a == bus.q_c);

    // With a locked-out lane the survivors must agree exactly; any split is unresolvable.
    always_comb begin : classify
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        w_voted       = (bus.q_a & bus.q_b) | (bus.q_a & bus.q_c) | (bus.q_b & bus.q_c);
        w_clean       = 1'b0;
        w_single      = 1'b0;
        w_single_lane = 2'd0;
        w_fatal_cond  = 1'b0;
        case (r_lane_dis)
            3'b000: begin
                if (w_eq_ab && w_eq_bc) begin
                    w_clean = 1'b1;
                end else if (w_eq_bc) begin
                    w_single      = 1'b1;
                    w_single_lane = 2'd0;
                end else if (w_eq_ac) begin
                    w_single      = 1'b1;
                    w_single_lane = 2'd1;
                end else if (w_eq_ab) begin
                    w_single      = 1'b1;
                    w_single_lane = 2'd2;
                end else begin
                    w_fatal_cond = 1'b1;
                end
            end
            3'b001: begin w_voted = bus.q_b; w_clean = w_eq_bc; w_fatal_cond = !w_eq_bc; end
            3'b010: begin w_voted = bus.q_a; w_clean = w_eq_ac; w_fatal_cond = !w_eq_ac; end
            3'b100: begin w_voted = bus.q_a; w_clean = w_eq_ab; w_fatal_cond = !w_eq_ab; end
            3'b011: begin w_voted = bus.q_c; w_fatal_cond = 1'b1; end
            3'b101: begin w_voted = bus.q_b; w_fatal_cond = 1'b1; end
            3'b110: begin w_voted = bus.q_a; w_fatal_cond = 1'b1; end
            default: begin w_voted = '0; w_fatal_cond = 1'b1; end
        endcase
    end

    assign w_flt_oh = 3'b001 << r_flt_lane;

    always_comb begin : cnt_select
        w_cnt_cur = r_fault_cnt[0];
        for (int i = 1; i < 3; i++) begin
            if (r_flt_lane == 2'(i)) w_cnt_cur = r_fault_cnt[i];
        end
        w_cnt_inc = (w_cnt_cur == CNT_MAX) ? w_cnt_cur : w_cnt_cur + CW'(1);
    end

    always_comb begin : next_state
        w_state_nxt    = r_state;
        w_pcnt_nxt     = r_pcnt;
        w_flt_lane_nxt = r_flt_lane;
        w_retry_nxt    = r_retry;
        w_load_val_nxt = r_load_val;
        w_lane_dis_nxt = r_lane_dis;
        for (int i = 0; i < 3; i++) w_fault_cnt_nxt[i] = r_fault_cnt[i];

        if (r_state != S_FATAL && w_fatal_cond) begin
            w_state_nxt = S_FATAL;
        end else begin
            case (r_state)
                S_MON: begin
                    if (w_single) begin
                        w_flt_lane_nxt = w_single_lane;
                        w_pcnt_nxt     = 4'd1;
                        if (CONFIRM_C == 4'd1) begin
                            w_state_nxt    = S_LOAD;
                            w_load_val_nxt = w_voted;
                        end else begin
                            w_state_nxt = S_CONF;
                        end
                    end
                end
                S_CONF: begin
                    if (!w_single) begin
                        w_state_nxt = S_MON;
                        w_pcnt_nxt  = 4'd0;
                    end else if (w_single_lane != r_flt_lane) begin
                        w_flt_lane_nxt = w_single_lane;
                        w_pcnt_nxt     = 4'd1;
                    end else if (r_pcnt + 4'd1 >= CONFIRM_C) begin
                        w_state_nxt    = S_LOAD;
                        w_pcnt_nxt     = 4'd0;
                        w_load_val_nxt = w_voted;
                    end else begin
                        w_pcnt_nxt = r_pcnt + 4'd1;
                    end
                end
                S_LOAD: w_state_nxt = S_CHECK;
                S_CHECK: begin
                    w_state_nxt = S_MON;
                    if (w_clean) begin
                        for (int i = 0; i < 3; i++) begin
                            if (r_flt_lane == 2'(i)) w_fault_cnt_nxt[i] = w_cnt_inc;
                        end
                        w_retry_nxt = '0;
                        if (w_cnt_inc >= LIMIT_C) w_lane_dis_nxt = r_lane_dis | w_flt_oh;
                    end else if (r_retry + RW'(1) >= RETRY_C) begin
                        w_lane_dis_nxt = r_lane_dis | w_flt_oh;
                        w_retry_nxt    = '0;
                    end else begin
                        w_retry_nxt    = r_retry + RW'(1);
                        w_state_nxt    = S_LOAD;
                        w_load_val_nxt = w_voted;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_MON;
            r_pcnt     <= '0;
            r_flt_lane <= '0;
            r_retry    <= '0;
            r_load_val <= '0;
            r_lane_dis <= '0;
            // NOTE: this small array is architecturally visible, so it is reset like plain registers.
            for (int i = 0; i < 3; i++) r_fault_cnt[i] <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_flt_lane <= w_flt_lane_nxt;
            r_retry    <= w_retry_nxt;
            r_load_val <= w_load_val_nxt;
            r_lane_dis <= w_lane_dis_nxt;
            for (int i = 0; i < 3; i++) r_fault_cnt[i] <= w_fault_cnt_nxt[i];
        end
    end

    // Status outputs that mix in live inputs are held low while reset is asserted.
    assign bus.voted_out   = w_voted;
    assign bus.cnt_enable  = rst && bus.enable_in && (r_state == S_MON || r_state == S_CONF);
    assign bus.load_en     = (r_state == S_LOAD) ? w_flt_oh : 3'b000;
    assign bus.load_val    = r_load_val;
    assign bus.lane_dis    = r_lane_dis;
    assign bus.fault_cnt_a = r_fault_cnt[0];
    assign bus.fault_cnt_b = r_fault_cnt[1];
    assign bus.fault_cnt_c = r_fault_cnt[2];
    assign bus.err_flag    = rst && (r_state != S_FATAL) && (r_state != S_MON || !w_clean);
    assign bus.fatal       = (r_state == S_FATAL);
    assign bus.busy        = (r_state == S_LOAD || r_state == S_CHECK);
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: directed scenarios plus biased random replica traffic,
// compared every cycle against a phase-level behavioural model of the supervisor.
module tb_tmr_scrub_ctrl;
    localparam int W = 8, CONFIRM = 2, MAX_RETRY = 2, FAULT_LIMIT = 3, CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tmr_scrub_ctrl_if #(.W(W), .CW(CW)) bus ();

    tmr_scrub_ctrl #(
        .W(W), .CONFIRM(CONFIRM), .MAX_RETRY(MAX_RETRY), .FAULT_LIMIT(FAULT_LIMIT), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: "watching" covers monitor+confirm via a run length of same-lane faults;
    // a resync is the two-beat sequence load then check.
    bit m_fatal;
    int m_step;          // 0 watching, 1 load beat, 2 check beat
    int m_run_lane, m_run_len;
    int m_flt, m_retry, m_load_val;
    int m_cnt[3];
    bit m_dis[3];

    task automatic model_reset();
        m_fatal = 0; m_step = 0; m_run_lane = 0; m_run_len = 0;
        m_flt = 0; m_retry = 0; m_load_val = 0;
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_dis[i] = 0; end
    endtask

    // kind: 0 clean, 1 single-lane fault on 'lane', 2 no trustworthy majority
    function automatic void classify(input int qa, input int qb, input int qc,
                                     output int kind, output int lane, output int vote);
        int q[3];
        int en[$];
        q[0] = qa; q[1] = qb; q[2] = qc;
        kind = 2; lane = 0; vote = 0;
        for (int i = 0; i < 3; i++) if (!m_dis[i]) en.push_back(i);
        if (en.size() == 3) begin
            for (int b = 0; b < W; b++) begin
                int ones = 0;
                for (int i = 0; i < 3; i++) ones += (q[i] >> b) & 1;
                if (ones >= 2) vote |= (1 << b);
            end
            if (q[0] == q[1] && q[1] == q[2]) kind = 0;
            else begin
                for (int i = 0; i < 3; i++)
                    if (q[(i + 1) % 3] == q[(i + 2) % 3]) begin kind = 1; lane = i; end
            end
        end else begin
            if (en.size() > 0) vote = q[en[0]];
            if (en.size() == 2 && q[en[0]] == q[en[1]]) kind = 0;
        end
    endfunction

    task automatic model_step();
        int kind, lane, vote;
        if (rst !== 1'b1) begin model_reset(); return; end
        if (m_fatal) return;
        classify(int'(bus.q_a), int'(bus.q_b), int'(bus.q_c), kind, lane, vote);
        if (kind == 2) begin m_fatal = 1; return; end
        case (m_step)
            0: begin
                if (kind == 1) begin
                    if (m_run_len > 0 && m_run_lane == lane) m_run_len++;
                    else begin m_run_lane = lane; m_run_len = 1; end
                    if (m_run_len >= CONFIRM) begin
                        m_step = 1; m_flt = lane; m_load_val = vote; m_run_len = 0;
                    end
                end else m_run_len = 0;
            end
            1: m_step = 2;
            default: begin
                m_step = 0;
                if (kind == 0) begin
                    if (m_cnt[m_flt] < 2**CW - 1) m_cnt[m_flt]++;
                    m_retry = 0;
                    if (m_cnt[m_flt] >= FAULT_LIMIT) m_dis[m_flt] = 1;
                end else begin
                    m_retry++;
                    if (m_retry >= MAX_RETRY) begin m_dis[m_flt] = 1; m_retry = 0; end
                    else begin m_step = 1; m_load_val = vote; end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int kind, lane, vote;
        bit live;
        classify(int'(bus.q_a), int'(bus.q_b), int'(bus.q_c), kind, lane, vote);
        live = (rst === 1'b1) && !m_fatal;
        check("voted_out", 32'(bus.voted_out), 32'(vote));
        check("fatal", 32'(bus.fatal), 32'(m_fatal));
        check("busy", 32'(bus.busy), 32'(!m_fatal && m_step != 0));
        check("load_en", 32'(bus.load_en), (!m_fatal && m_step == 1) ? 32'(1 << m_flt) : 32'd0);
        check("load_val", 32'(bus.load_val), 32'(m_load_val));
        check("lane_dis", 32'(bus.lane_dis), 32'({m_dis[2], m_dis[1], m_dis[0]}));
        check("fault_cnt_a", 32'(bus.fault_cnt_a), 32'(m_cnt[0]));
        check("fault_cnt_b", 32'(bus.fault_cnt_b), 32'(m_cnt[1]));
        check("fault_cnt_c", 32'(bus.fault_cnt_c), 32'(m_cnt[2]));
        check("cnt_enable", 32'(bus.cnt_enable),
              32'(live && m_step == 0 && bus.enable_in === 1'b1));
        check("err_flag", 32'(bus.err_flag),
              32'(live && (m_step != 0 || m_run_len > 0 || kind != 0)));
    endtask

    always @(negedge clk) if (chk_on) compare_all();

    task automatic tick(input int en, input int a, input int b, input int c);
        bus.enable_in = (en != 0);
        bus.q_a = 8'(a);
        bus.q_b = 8'(b);
        bus.q_c = 8'(c);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        #1;
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int base, ep_lane, ep_len, ep_val, a, b, c, en;
        bus.enable_in = 1'b0;
        bus.q_a = '0; bus.q_b = '0; bus.q_c = '0;
        model_reset();
        #1;
        check("rst_fatal", 32'(bus.fatal), 32'd0);
        check("rst_load_en", 32'(bus.load_en), 32'd0);
        check("rst_cnt_enable", 32'(bus.cnt_enable), 32'd0);
        check("rst_lane_dis", 32'(bus.lane_dis), 32'd0);
        chk_on = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b1;

        // Clean counting
        for (int i = 0; i <= 10; i++) tick(1, i, i, i);
        check("count_voted", 32'(bus.voted_out), 32'h0A);
        check("count_err", 32'(bus.err_flag), 32'd0);
        check("count_cnt_en", 32'(bus.cnt_enable), 32'd1);

        // Persistent lane-b fault resynced
        tick(1, 8'h07, 8'hFF, 8'h07);
        check("b_conf_err", 32'(bus.err_flag), 32'd1);
        check("b_conf_load_en", 32'(bus.load_en), 32'd0);
        tick(1, 8'h07, 8'hFF, 8'h07);
        check("b_load_en", 32'(bus.load_en), 32'b010);
        check("b_load_val", 32'(bus.load_val), 32'h07);
        check("b_load_cnt_en", 32'(bus.cnt_enable), 32'd0);
        tick(1, 8'h07, 8'hFF, 8'h07);
        check("b_check_busy", 32'(bus.busy), 32'd1);
        check("b_check_cnt_en", 32'(bus.cnt_enable), 32'd0);
        tick(1, 8'h07, 8'h07, 8'h07);
        check("b_fault_cnt", 32'(bus.fault_cnt_b), 32'd1);
        check("b_back_cnt_en", 32'(bus.cnt_enable), 32'd1);

        // One-cycle lane-c glitch filtered
        tick(1, 8'h08, 8'h08, 8'h55);
        tick(1, 8'h08, 8'h08, 8'h08);
        check("c_glitch_load_en", 32'(bus.load_en), 32'd0);
        check("c_glitch_busy", 32'(bus.busy), 32'd0);
        check("c_glitch_cnt", 32'(bus.fault_cnt_c), 32'd0);

        // Asynchronous reset in the middle of a load
        tick(1, 8'h33, 8'h20, 8'h20);
        tick(1, 8'h33, 8'h20, 8'h20);
        check("a_load_en", 32'(bus.load_en), 32'b001);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_load_en", 32'(bus.load_en), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_cnt_b", 32'(bus.fault_cnt_b), 32'd0);
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b1;

        // Lane c stuck: two failed checks lock it out
        tick(1, 9, 9, 9);
        repeat (4) tick(1, 9, 9, 8'hEF);
        check("stuck_retry_load_en", 32'(bus.load_en), 32'b100);
        check("stuck_retry_load_val", 32'(bus.load_val), 32'h09);
        repeat (2) tick(1, 9, 9, 8'hEF);
        check("stuck_lane_dis", 32'(bus.lane_dis), 32'b100);
        check("stuck_cnt_c", 32'(bus.fault_cnt_c), 32'd0);
        tick(1, 8'h3C, 8'h3C, 8'hEF);
        check("dis_voted", 32'(bus.voted_out), 32'h3C);
        check("dis_fatal", 32'(bus.fatal), 32'd0);
        tick(1, 8'h3C, 8'h3D, 8'h3C);
        check("dis_split_fatal", 32'(bus.fatal), 32'd1);
        apply_reset();

        // Three-way disagreement is terminal until reset
        tick(1, 1, 2, 3);
        check("multi_fatal", 32'(bus.fatal), 32'd1);
        check("multi_cnt_en", 32'(bus.cnt_enable), 32'd0);
        repeat (2) tick(1, 5, 5, 5);
        check("multi_sticky", 32'(bus.fatal), 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check("multi_rst_clear", 32'(bus.fatal), 32'd0);
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b1;

        // FAULT_LIMIT successful resyncs on lane a lock it out
        for (int k = 1; k <= 3; k++) begin
            repeat (3) tick(1, 8'hAA, 8'h10, 8'h10);
            tick(1, 8'h10, 8'h10, 8'h10);
            check("limit_cnt_a", 32'(bus.fault_cnt_a), 32'(k));
        end
        check("limit_lane_dis", 32'(bus.lane_dis), 32'b001);
        tick(1, 8'hAA, 8'h10, 8'h10);
        check("limit_voted", 32'(bus.voted_out), 32'h10);
        check("limit_err", 32'(bus.err_flag), 32'd0);
        apply_reset();

        // Biased random traffic
        base = 0; ep_lane = 0; ep_len = 0; ep_val = 0;
        for (int n = 0; n < 3000; n++) begin
            if ((m_fatal && $urandom_range(0, 7) == 0) || $urandom_range(0, 999) == 0) begin
                apply_reset();
                continue;
            end
            if ($urandom_range(0, 3) != 0) base = (base + 1) & 255;
            a = base; b = base; c = base;
            en = ($urandom_range(0, 4) != 0) ? 1 : 0;
            if (ep_len == 0 && $urandom_range(0, 9) == 0) begin
                ep_lane = int'($urandom_range(0, 2));
                ep_len  = int'($urandom_range(1, 7));
                ep_val  = base ^ int'($urandom_range(1, 255));
            end
            if (ep_len > 0) begin
                if (ep_lane == 0) a = ep_val;
                else if (ep_lane == 1) b = ep_val;
                else c = ep_val;
                ep_len--;
            end else if ($urandom_range(0, 59) == 0) begin
                b = base ^ 1;
                c = base ^ 2;
            end
            tick(en, a, b, c);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
